// File: rtl/vga_tile_addr_gen_if.sv
// Pixel-position / tile-address bundle between the VGA driver side and the
// tile address generator.
interface vga_tile_addr_gen_if #(
   parameter int PW = 12,
   parameter int AW = 8
);
   logic [PW-1:0] pos_x;
   logic [PW-1:0] pos_y;
   logic [2:0]    mode;
   logic [AW-1:0] scroll_x;
   logic [AW-1:0] addr_out;
   logic          in_grid;
   logic          frame_start;

   modport master (
      output pos_x, pos_y, mode, scroll_x,
      input  addr_out, in_grid, frame_start
   );

   modport slave (
      input  pos_x, pos_y, mode, scroll_x,
      output addr_out, in_grid, frame_start
   );
endinterface

// File: rtl/vga_tile_addr_gen.sv
// Two-stage pipeline mapping the VGA next-pixel position to a tile address,
// with mode and scroll latched once per frame so a frame never tears.
module vga_tile_addr_gen #(
   parameter int SCREEN_X   = 1024,
   parameter int SCREEN_Y   = 768,
   parameter int SCALE_LOG2 = 6,
   parameter int PW         = 12,
   parameter int AW         = 8,
   parameter int GRID_W     = SCREEN_X >> SCALE_LOG2,
   parameter int GRID_H     = SCREEN_Y >> SCALE_LOG2
) (
   input logic              clk,
   input logic              rst,
   vga_tile_addr_gen_if.slave bus
);
   localparam int TW = PW - SCALE_LOG2;
   localparam int WW = PW + AW;
   localparam logic [WW-1:0] GW = WW'(GRID_W);
   localparam logic [WW-1:0] GH = WW'(GRID_H);

   logic          prev_zero_q;
   logic [2:0]    shadow_mode_q, shadow_mode_d;
   logic [AW-1:0] shadow_scroll_q, shadow_scroll_d;

   logic [TW-1:0] tx_q, tx_d;
   logic [TW-1:0] ty_q, ty_d;
   logic          v_q, v_d;
   logic          fs1_q;

   logic [AW-1:0] addr_q, addr_d;
   logic          in_grid_q;
   logic          fs2_q;

   logic          is_zero;
   logic          fs_det;
   logic [WW-1:0] sx;
   logic [WW-1:0] row;

   always_comb begin
      is_zero = (bus.pos_x == '0) && (bus.pos_y == '0);
      fs_det  = is_zero && !prev_zero_q;

      tx_d = bus.pos_x[PW-1:SCALE_LOG2];
      ty_d = bus.pos_y[PW-1:SCALE_LOG2];
      v_d  = (WW'(tx_d) < GW) && (WW'(ty_d) < GH);

      shadow_mode_d   = shadow_mode_q;
      shadow_scroll_d = shadow_scroll_q;
      if (fs_det) begin
         shadow_mode_d   = bus.mode;
         // An out-of-range scroll would break the single-subtract wrap below.
         shadow_scroll_d = (WW'(bus.scroll_x) >= GW) ? '0 : bus.scroll_x;
      end
   end

   always_comb begin
      sx = WW'(tx_q) + WW'(shadow_scroll_q);
      if (sx >= GW) begin
         sx = sx - GW;
      end
      row = WW'(ty_q) * GW;

      case (shadow_mode_q)
         3'd1:    addr_d = AW'(sx);
         3'd2:    addr_d = AW'(ty_q);
         3'd3:    addr_d = AW'(sx + WW'(ty_q));
         3'd4:    addr_d = AW'(sx * WW'(ty_q));
         3'd5:    addr_d = AW'((GW - WW'(1) - sx) + row);
         default: addr_d = AW'(sx + row);
      endcase
      if (!v_q) begin
         addr_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_zero_q     <= 1'b0;
         shadow_mode_q   <= '0;
         shadow_scroll_q <= '0;
         tx_q            <= '0;
         ty_q            <= '0;
         v_q             <= 1'b0;
         fs1_q           <= 1'b0;
         addr_q          <= '0;
         in_grid_q       <= 1'b0;
         fs2_q           <= 1'b0;
      end else begin
         prev_zero_q     <= is_zero;
         shadow_mode_q   <= shadow_mode_d;
         shadow_scroll_q <= shadow_scroll_d;
         tx_q            <= tx_d;
         ty_q            <= ty_d;
         v_q             <= v_d;
         fs1_q           <= fs_det;
         addr_q          <= addr_d;
         in_grid_q       <= v_q;
         fs2_q           <= fs1_q;
      end
   end

   assign bus.addr_out    = addr_q;
   assign bus.in_grid     = in_grid_q;
   assign bus.frame_start = fs2_q;
endmodule

// File: tb/tb_vga_tile_addr_gen.sv
// Directed-vector bench for vga_tile_addr_gen on the default 16x12 grid of
// 64-pixel tiles.
module tb_vga_tile_addr_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;

   vga_tile_addr_gen_if #(.PW(12), .AW(8)) bus ();

   vga_tile_addr_gen dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int frame;
      int mode;
      int scroll;
      int x;
      int y;
      int exp_addr;
      int exp_in;
   } vec_t;

   vec_t vecs[16];
   int errors = 0;
   int checks = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_pos(input int x, input int y);
      bus.pos_x = 12'(x);
      bus.pos_y = 12'(y);
   endtask

   // Present (0,0) with the wanted mode/scroll, then scramble them so any
   // sampling outside the frame-start edge shows up in later addresses.
   task automatic frame(input int m, input int s);
      set_pos(640, 400);
      step();
      set_pos(0, 0);
      bus.mode     = 3'(m);
      bus.scroll_x = 8'(s);
      step();
      chk("fs_early", int'(bus.frame_start), 0);
      bus.mode     = 3'(m + 3);
      bus.scroll_x = 8'd9;
      step();
      chk("fs_pulse", int'(bus.frame_start), 1);
      step();
      chk("fs_single", int'(bus.frame_start), 0);
   endtask

   initial begin
      int sx[4];
      int sy[4];
      int se[4];

      vecs[0]  = '{1, 0, 0,  130, 200,  50, 1};
      vecs[1]  = '{0, 0, 0, 1030, 100,   0, 0};
      vecs[2]  = '{0, 0, 0,  100, 770,   0, 0};
      vecs[3]  = '{0, 0, 0,   64,  64,  17, 1};
      vecs[4]  = '{0, 0, 0, 1023, 767, 191, 1};
      vecs[5]  = '{1, 0, 15,  64,   0,   0, 1};
      vecs[6]  = '{1, 0, 20,  64,   0,   1, 1};
      vecs[7]  = '{1, 5, 0,    0,  64,  31, 1};
      vecs[8]  = '{1, 7, 0,  192, 128,  35, 1};
      vecs[9]  = '{1, 4, 0,  128, 192,   6, 1};
      vecs[10] = '{1, 1, 5,  640,   0,  15, 1};
      vecs[11] = '{1, 1, 6,  640,   0,   0, 1};
      vecs[12] = '{1, 2, 0,  640, 700,  10, 1};
      vecs[13] = '{1, 3, 0,  640, 700,  20, 1};
      vecs[14] = '{1, 4, 15, 128, 192,   3, 1};
      vecs[15] = '{1, 5, 3,  320, 128,  39, 1};

      set_pos(640, 400);
      bus.mode     = 3'd0;
      bus.scroll_x = 8'd0;
      #1;
      chk("rst_addr", int'(bus.addr_out), 0);
      chk("rst_in_grid", int'(bus.in_grid), 0);
      chk("rst_fs", int'(bus.frame_start), 0);
      step();
      step();
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         if (vecs[i].frame != 0) begin
            frame(vecs[i].mode, vecs[i].scroll);
         end
         set_pos(vecs[i].x, vecs[i].y);
         step();
         step();
         chk($sformatf("vec%0d_addr", i), int'(bus.addr_out), vecs[i].exp_addr);
         chk($sformatf("vec%0d_in_grid", i), int'(bus.in_grid), vecs[i].exp_in);
      end

      // Mode change between frame starts must not affect the output.
      frame(0, 0);
      set_pos(64, 64);
      step();
      step();
      chk("mid_pre", int'(bus.addr_out), 17);
      bus.mode = 3'd4;
      step();
      step();
      chk("mid_mode", int'(bus.addr_out), 17);
      frame(4, 0);
      set_pos(128, 192);
      step();
      step();
      chk("mid_after_frame", int'(bus.addr_out), 6);

      // Back-to-back pixels: one result per cycle, exactly two cycles late.
      frame(0, 0);
      sx = '{64, 130, 1030, 192};
      sy = '{64, 200, 100, 128};
      se = '{17, 50, 0, 35};
      for (int i = 0; i < 5; i++) begin
         if (i < 4) set_pos(sx[i], sy[i]);
         else       set_pos(640, 400);
         step();
         if (i >= 1) chk($sformatf("stream%0d", i - 1), int'(bus.addr_out), se[i - 1]);
      end

      // Asynchronous reset mid-frame drops back to mode 0, no scroll.
      frame(4, 0);
      set_pos(128, 192);
      step();
      step();
      chk("pre_rst_addr", int'(bus.addr_out), 6);
      rst = 1'b1;
      #2;
      chk("async_rst_addr", int'(bus.addr_out), 0);
      chk("async_rst_in_grid", int'(bus.in_grid), 0);
      chk("async_rst_fs", int'(bus.frame_start), 0);
      #1;
      rst = 1'b0;
      step();
      step();
      step();
      chk("post_rst_addr", int'(bus.addr_out), 50);
      chk("post_rst_in_grid", int'(bus.in_grid), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
